bpu_bht: RTL

- Parametrised dynamic successor to the static fetch-stage predictor.
- Replaces the "backward branch taken" rule with a table of 2-bit saturating counters, indexed in bimodal or gshare mode.
- Sits in the IFU beside PC generation and produces the next fetch PC combinationally.
- Counters and global history are trained by the EX stage when a branch resolves; a saturating mispredict counter is provided for performance measurement.

---
 rtl/bpu_bht.sv | 54 +++++
 1 files changed

// File: rtl/bpu_bht.sv
// bpu_bht: bimodal/gshare branch history table of 2-bit counters producing a zero-latency next-PC prediction
module bpu_bht #(
    parameter int         XLEN     = 32,
    parameter int         BHT_IDX  = 6,
    parameter int         MODE     = 0,
    parameter int         GHR_LEN  = 6,
    parameter logic [1:0] CNT_INIT = 2'b01
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [XLEN-1:0]    pc,
    input  logic [31:0]        imm,
    input  logic [6:0]         opcode,
    output logic [XLEN-1:0]    pc_pred,
    output logic               pred_taken,
    output logic [BHT_IDX-1:0] pred_idx,
    input  logic               upd_valid,
    input  logic [BHT_IDX-1:0] upd_idx,
    input  logic               upd_taken,
    input  logic               upd_mispred,
    output logic [31:0]        mispred_cnt
);
    localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
    localparam logic [6:0] OPCODE_BREACH = 7'b1100011;

    logic [1:0]         bht [2**BHT_IDX];
    logic [GHR_LEN-1:0] ghr;
    logic [BHT_IDX-1:0] pc_idx;
    logic [XLEN-1:0]    imm_x;
    logic [1:0]         cur;

    always_comb begin
        pc_idx     = pc[BHT_IDX+1:2];
        pred_idx   = (MODE == 1) ? (pc_idx ^ BHT_IDX'(ghr)) : pc_idx;
        imm_x      = XLEN'($signed(imm));
        pred_taken = (opcode == OPCODE_JAL) | ((opcode == OPCODE_BREACH) & bht[pred_idx][1]);
        pc_pred    = pred_taken ? pc + imm_x : pc + XLEN'(4);
        cur        = bht[upd_idx];
    end

    // Training is non-speculative: the read side never sees this cycle's write
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2**BHT_IDX; i++) bht[i] <= CNT_INIT;
            ghr         <= '0;
            mispred_cnt <= '0;
        end else if (upd_valid) begin
            bht[upd_idx] <= upd_taken ? ((cur == 2'b11) ? cur : cur + 2'b01)
                                      : ((cur == 2'b00) ? cur : cur - 2'b01);
            ghr          <= GHR_LEN'({ghr, upd_taken});
            if (upd_mispred && mispred_cnt != '1) mispred_cnt <= mispred_cnt + 32'd1;
        end
    end
endmodule
